// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns byte/half/word loads and stores into
// word-aligned memory transactions, with read-modify-write for sub-word stores.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wdin,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      READ   = 3'd1,
      WRITE  = 3'd2,
      RMW_RD = 3'd3,
      RMW_WR = 3'd4,
      RESP   = 3'd5,
      ERR    = 3'd6
   } state_t;

   state_t      state;
   logic        we_q;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [31:0] merge_q;
   logic [31:0] rdata_hold_q;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return lo[0];
         default: return (lo != 2'b00);
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lo, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lo, 3'b000} +: 8];
      h = lo[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   return uns ? {24'h000000, b} : {{24{b[7]}}, b};
         2'b01:   return uns ? {16'h0000, h} : {{16{h[15]}}, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                               input logic [1:0] size, input logic [1:0] lo);
      logic [31:0] w;
      w = word;
      case (size)
         2'b00: w[{lo, 3'b000} +: 8] = wd[7:0];
         2'b01: begin
            if (lo[1]) begin
               w[31:16] = wd[15:0];
            end else begin
               w[15:0] = wd[15:0];
            end
         end
         default: w = wd;
      endcase
      return w;
   endfunction

   assign req_ready = (state == IDLE);
   assign mem_adr   = {addr_q[31:2], 2'b00};

   // Control FSM: request latching, memory data capture and response flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         unsigned_q   <= 1'b0;
         addr_q       <= 32'h0000_0000;
         wdata_q      <= 32'h0000_0000;
         rdata_q      <= 32'h0000_0000;
         merge_q      <= 32'h0000_0000;
         rdata_hold_q <= 32'h0000_0000;
         resp_valid   <= 1'b0;
         resp_err     <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q       <= req_we;
                  size_q     <= req_size;
                  unsigned_q <= req_unsigned;
                  addr_q     <= req_addr;
                  wdata_q    <= req_wdata;
                  if (is_misaligned(req_size, req_addr[1:0])) begin
                     state      <= ERR;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (!req_we) begin
                     state <= READ;
                  end else if (req_size[1]) begin
                     state <= WRITE;
                  end else begin
                     state <= RMW_RD;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            READ: begin
               rdata_q    <= mem_rd;
               state      <= RESP;
               resp_valid <= 1'b1;
            end
            WRITE: begin
               state      <= RESP;
               resp_valid <= 1'b1;
            end
            RMW_RD: begin
               merge_q <= store_merge(mem_rd, wdata_q, size_q, addr_q[1:0]);
               state   <= RMW_WR;
            end
            RMW_WR: begin
               state      <= RESP;
               resp_valid <= 1'b1;
            end
            RESP: begin
               if (!we_q) begin
                  rdata_hold_q <= load_extract(rdata_q, size_q, addr_q[1:0], unsigned_q);
               end else begin
                  rdata_hold_q <= rdata_hold_q;
               end
               state <= IDLE;
            end
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Memory write strobe/data and load result, decoded from the registered state.
   always_comb begin
      mem_we     = 1'b0;
      mem_wdin   = 32'h0000_0000;
      resp_rdata = rdata_hold_q;
      case (state)
         WRITE: begin
            mem_we   = 1'b1;
            mem_wdin = wdata_q;
         end
         RMW_WR: begin
            mem_we   = 1'b1;
            mem_wdin = merge_q;
         end
         RESP: begin
            if (!we_q) begin
               resp_rdata = load_extract(rdata_q, size_q, addr_q[1:0], unsigned_q);
            end else begin
               resp_rdata = rdata_hold_q;
            end
         end
         default: begin
            mem_we = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side data-memory access unit for the pipelined miniRV core, sitting in the MEM stage between the pipeline and the word-wide data-memory wrapper. It accepts one load/store request at a time and converts byte/halfword/word accesses into word-aligned memory transactions, using read-modify-write for sub-word stores. It returns sign- or zero-extended load data and flags misaligned accesses without touching memory. The pipeline stalls on `req_ready` low.

## Interface
- No parameters.
- `clk` in 1: core clock. The memory wrapper samples writes on the falling edge of `clk`; reads are asynchronous.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle; `req_ready = (state == IDLE)`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `req_unsigned` in 1: zero-extend loads (LBU/LHU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_err` out 1: misaligned; valid with `resp_valid`.
- `resp_rdata` out 32: load result; held until the next load response.
- `mem_adr` out 32: word-aligned byte address, `{addr_q[31:2], 2'b00}`.
- `mem_wdin` out 32: write data to memory.
- `mem_we` out 1: write enable.
- `mem_rd` in 32: asynchronous read data for `mem_adr`.

## Operation
- A request is accepted at a rising edge with `req_valid && req_ready`. All request fields are latched into `*_q` registers.
- `req_valid` is ignored while busy.
- Misaligned: half with `addr[0] = 1`, or word with `addr[1:0] != 0`. Goes to state ERR. No memory access occurs.
- FSM states: IDLE, READ, WRITE, RMW_RD, RMW_WR, RESP, ERR.
- IDLE transitions on accept:
  - misaligned → ERR
  - load → READ
  - word store → WRITE
  - byte/half store → RMW_RD
- READ: drive `mem_adr` and capture `mem_rd` into `rdata_q` at the rising edge. → RESP.
- WRITE: `mem_we = 1`, `mem_wdin = wdata_q`. → RESP.
- RMW_RD: drive `mem_adr` and capture the merged word into `merge_q` at the rising edge. → RMW_WR.
  - Byte store: lane `addr_q[1:0]` is replaced by `wdata_q[7:0]`.
  - Half store: lane `addr_q[1]` is replaced by `wdata_q[15:0]`.
- RMW_WR: `mem_we = 1`, `mem_wdin = merge_q`. → RESP.
- RESP: `resp_valid = 1`, `resp_err = 0`. For loads, `resp_rdata` is updated from `rdata_q`. → IDLE.
- ERR: `resp_valid = 1`, `resp_err = 1`. `resp_rdata` is unchanged. → IDLE.
- Load extraction:
  - Byte: `rdata_q[8*addr[1:0] +: 8]`.
  - Half: `rdata_q[16*addr[1] +: 16]`.
  - Sign-extended unless `req_unsigned`. `req_unsigned` is ignored for word loads.
- `mem_we` is decoded combinationally from state (WRITE/RMW_WR only). It is never asserted in any other state.
- `mem_wdin` is 0 outside write states. `mem_adr` holds `addr_q` word-aligned in all non-IDLE states.

## Timing
- Reset values:
  - state = IDLE
  - `resp_valid = 0`, `resp_err = 0`, `resp_rdata = 0`
  - `mem_we = 0`, `mem_wdin = 0`, `mem_adr = 0`
  - all `*_q` = 0
- Latency from the accept edge E0 to the `resp_valid` cycle:
  - Misaligned: cycle after E0 (1).
  - Load or word store: cycle after E1 (2).
  - Sub-word store: cycle after E2 (3).
- Throughput: the next request is accepted no earlier than the edge ending the RESP/ERR cycle, since `req_ready` is 0 during RESP.
- A write commits at the falling edge inside the WRITE/RMW_WR cycle. Read-back in a following READ sees the new data.
- Reset asserted mid-operation returns the FSM to IDLE immediately and forces `mem_we` low. If `rst_n` falls before the falling edge of a write cycle, no write occurs. No partial RMW write is ever issued.
- Back-to-back accesses to the same word (store then load) return the stored value; no forwarding is needed.

## Test plan
- Preload word 0x4000 = 0x8899AABB. LB 0x4001 → `resp_rdata = 0xFFFFFFAA`, `resp_valid` 2 cycles after accept. LBU 0x4001 → `0x000000AA`.
- LH 0x4002 → `0xFFFF8899`. LHU 0x4002 → `0x00008899`. LW 0x4000 → `0x8899AABB`.
- SB 0x4002 with wdata 0x12345677 → exactly one `mem_we` pulse in cycle 2, `mem_wdin = 0x8877AABB`. A subsequent LW returns 0x8877AABB.
- SH 0x4000 with wdata 0x0000CAFE → memory word becomes 0x8899CAFE. SW 0x4004 with 0xDEADBEEF → `mem_we` in cycle 1 only, `mem_adr = 0x4004`.
- LW 0x4002 and SH 0x4001 → `resp_valid = 1` and `resp_err = 1` in the cycle after accept. `mem_we` is never high. `resp_rdata` is unchanged.
- Assert `rst_n` low during RMW_RD of SB 0x4000 → `mem_we` stays 0, memory is unchanged. After release: `req_ready = 1`, all outputs 0.
